mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction fetch path and the load/store path of the MIPS core.
- Sits between the fetch unit, which provides the PC as the fetch address, the data-memory stage, and the external memory port.
- Serialises accesses with one outstanding transaction at a time, prioritises data accesses, and bounds fetch starvation.
- Drives pc_stall so the fetch unit holds its PC until the instruction returns.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- STARVE_LIMIT, 3, maximum consecutive data grants while a fetch is pending before fetch is forced; range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- if_req  input  1  fetch request; held with if_addr stable until if_gnt.
- if_addr  input  ADDR_W  fetch address (PC).
- if_gnt  output  1  fetch request accepted this cycle.
- if_rvalid  output  1  one-cycle pulse; if_rdata valid.
- if_rdata  output  DATA_W  instruction word.
- pc_stall  output  1  fetch unit must hold PC.
- d_req  input  1  data request; d_we/d_addr/d_wdata held stable until d_gnt.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  store data.
- d_gnt  output  1  data request accepted this cycle.
- d_rvalid  output  1  one-cycle pulse; load data valid, or store complete.
- d_rdata  output  DATA_W  load data.
- mem_req  output  1  memory request.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_ready  input  1  memory accepts the request this cycle.
- mem_rvalid  input  1  response pulse; also used as the store acknowledge.
- mem_rdata  input  DATA_W  response data.

Behaviour:
- FSM states:
  - IDLE: may issue a request.
  - WAIT_IF: a fetch is outstanding.
  - WAIT_D: a data access is outstanding.
- Arbitration in IDLE (combinational):
  - Data selected if d_req and not (if_req and starve_cnt == STARVE_LIMIT).
  - Otherwise fetch selected if if_req.
  - mem_req = IDLE and (if_req or d_req).
  - mem_addr, mem_we and mem_wdata are muxed from the selected requester.
  - mem_we = 0 for a fetch.
  - mem_wdata = 0 when no data request is selected.
- Grant:
  - Selected gnt = mem_req and mem_ready, combinational, at most one per cycle.
  - On grant, go to WAIT_IF or WAIT_D.
  - If mem_ready = 0, stay in IDLE and re-arbitrate next cycle; the selection may change.
- Outside IDLE: mem_req = 0, both gnts = 0.
- Response:
  - In WAIT_x, mem_rvalid produces the matching x_rvalid in the same cycle, with x_rdata = mem_rdata; next state is IDLE.
  - if_rdata and d_rdata hold their last value otherwise; both are 0 after reset.
  - A new issue happens no earlier than the cycle after mem_rvalid.
  - Minimum cadence is a grant at cycle N, rvalid at N+1, the next grant at N+2.
- mem_rvalid in IDLE (stale, e.g. after reset) is discarded: no rvalid output is produced.
- starve_cnt (4 bits):
  - Clears on a fetch grant, or in any cycle where if_req = 0.
  - Increments, saturating at STARVE_LIMIT, on a data grant while if_req = 1.
- pc_stall = if_req and not if_rvalid, so the PC advances only in the cycle the instruction returns.
- Reset, asynchronous at any time including mid-transaction:
  - State = IDLE, starve_cnt = 0.
  - All gnt/rvalid/rdata outputs and mem_req/mem_we/mem_addr/mem_wdata are 0.
  - The outstanding transaction is abandoned.
- Requester dropping req before gnt is allowed and simply removes it from arbitration. Changing the address while req is held is a protocol error, with undefined behaviour.

Test Plan:
- Fetch only, mem_ready = 1, memory returns rvalid 1 cycle after grant with rdata = 0x2008_0005, if_addr = 0x0000_0004:
  - if_gnt at cycle 1, if_rvalid with if_rdata = 0x2008_0005 at cycle 2.
  - pc_stall = 1 at cycle 1 and 0 at cycle 2.
  - Next grant at cycle 3.
- Simultaneous if_req and d_req (load, d_addr = 0x100), STARVE_LIMIT = 3, d_req held continuously:
  - Grant order is D, D, D, IF, D.
  - starve_cnt reads 1, 2, 3, then 0 after the fetch grant.
- Store d_we = 1, d_addr = 0x40, d_wdata = 0xDEAD_BEEF:
  - mem_we = 1 with matching addr and data at grant.
  - d_rvalid on ack.
  - No if_rvalid.
- mem_ready = 0 for 4 cycles with if_req held:
  - mem_req = 1 throughout, if_gnt = 0, pc_stall = 1.
  - Grant in the first cycle mem_ready = 1.
- rst pulsed in WAIT_D; memory then returns mem_rvalid:
  - Outputs are 0 immediately on reset.
  - The stale rvalid yields neither d_rvalid nor if_rvalid.
  - A fresh fetch completes normally afterwards.
- mem_rvalid arrives in the same cycle as new if_req/d_req:
  - No grant that cycle.
  - Grant occurs the following cycle.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory-port signals around the unified-memory arbiter.
// The master modport is the arbiter's view; slave is the environment (core + memory).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              pc_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
           mem_ready, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, pc_stall, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
           mem_ready, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, pc_stall, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, one transaction
// in flight, data first, with fetch forced after STARVE_LIMIT consecutive data grants.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_D} state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e            state_q, state_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic idle, sel_d, sel_if, if_gnt, d_gnt, if_rvalid, d_rvalid;

  // Requests are masked while rst is high so the memory port reads all-zero during reset.
  assign idle   = !rst && (state_q == IDLE);
  assign sel_d  = idle && bus.d_req && !(bus.if_req && (starve_cnt_q == LIMIT));
  assign sel_if = idle && bus.if_req && !sel_d;

  assign if_gnt    = sel_if && bus.mem_ready;
  assign d_gnt     = sel_d && bus.mem_ready;
  assign if_rvalid = (state_q == WAIT_IF) && bus.mem_rvalid;
  assign d_rvalid  = (state_q == WAIT_D) && bus.mem_rvalid;

  assign bus.mem_req   = idle && (bus.if_req || bus.d_req);
  assign bus.mem_we    = sel_d && bus.d_we;
  assign bus.mem_addr  = sel_d ? bus.d_addr : (sel_if ? bus.if_addr : '0);
  assign bus.mem_wdata = sel_d ? bus.d_wdata : '0;

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.if_rvalid = if_rvalid;
  assign bus.d_rvalid  = d_rvalid;
  assign bus.if_rdata  = if_rdata_d;
  assign bus.d_rdata   = d_rdata_d;
  assign bus.pc_stall  = bus.if_req && !if_rvalid;

  // NOTE: every signal gets a default before the branches so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    if_rdata_d   = if_rvalid ? bus.mem_rdata : if_rdata_q;
    d_rdata_d    = d_rvalid ? bus.mem_rdata : d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (if_gnt)     state_d = WAIT_IF;
        else if (d_gnt) state_d = WAIT_D;
      end
      WAIT_IF, WAIT_D: begin
        if (bus.mem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Counts data grants that overtook a waiting fetch; saturates so fetch stays forced.
    if (!bus.if_req || if_gnt)                  starve_cnt_d = '0;
    else if (d_gnt && (starve_cnt_q != LIMIT))  starve_cnt_d = starve_cnt_q + 4'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples the
  // pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

endmodule
